// File: rtl/sram_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sram_frame_reader
// Description : Read-side master for the 8-bit pixel SRAM (port 2). Scans one
//               WIDTH x HEIGHT frame in raster order and emits it as a
//               ready/valid pixel stream with start/end-of-packet markers. A
//               4-entry output FIFO absorbs the one-cycle SRAM read latency
//               against downstream backpressure.
// Ports       : clk, reset_n (async, active-low), enable (frame start level)
//               sram_* : SRAM port-2 read master (address/chipselect/readdata;
//                        write/writedata/clken tied off)
//               st_*   : pixel stream source (data/valid/ready/sop/eop)
//               busy   : high while a frame is being read or drained
//               frame_done : one-cycle pulse after the eop beat is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module sram_frame_reader #(
    parameter int                WIDTH     = 320,
    parameter int                HEIGHT    = 240,
    parameter int                ADDR_W    = 17,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [7:0]        sram_writedata,
    output logic              sram_clken,
    input  logic [7:0]        sram_readdata,
    output logic [7:0]        st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop,
    output logic              busy,
    output logic              frame_done
);

    localparam int c_NPIX       = WIDTH * HEIGHT;
    localparam int c_PIX_W      = (c_NPIX > 1) ? $clog2(c_NPIX) : 1;
    localparam int c_X_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_Y_W        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int c_FIFO_DEPTH = 4;

    localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(WIDTH - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Scan position: linear index drives the address, x/y drive the tags.
    logic [c_PIX_W-1:0] r_pix;
    logic [c_X_W-1:0]   r_x;
    logic [c_Y_W-1:0]   r_y;

    // Read in flight: tags registered alongside the issue so they line up
    // with sram_readdata one cycle later.
    logic r_inflight;
    logic r_tag_sop;
    logic r_tag_eop;

    // Output FIFO, entries are {eop, sop, data}.
    logic [9:0] r_fifo [0:c_FIFO_DEPTH-1];
    logic [1:0] r_wptr;
    logic [1:0] r_rptr;
    logic [2:0] r_count;

    logic r_frame_done;

    logic       w_pop;
    logic       w_push;
    logic [3:0] w_occ;
    logic       w_issue;
    logic       w_restart;
    logic       w_first;
    logic       w_last;
    logic [9:0] w_head;
    logic       w_eop_accept;

    // ------------------------------------------------------------------
    // Datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        w_head       = r_fifo[r_rptr];
        w_pop        = (r_count != 3'd0) && st_ready;
        w_push       = r_inflight;
        // Slots already claimed: stored entries plus the read whose data
        // lands this cycle, minus the entry leaving this cycle.
        w_occ        = {1'b0, r_count} + {3'b000, r_inflight} - {3'b000, w_pop};
        w_first      = (r_x == '0) && (r_y == '0);
        w_last       = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
        w_eop_accept = w_pop && w_head[9];
    end

    // ------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: next state, issue and scan restart
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                    w_restart   = 1'b1;
                end
            end
            S_RUN: begin
                if (w_occ < 4'(c_FIFO_DEPTH)) begin
                    w_issue = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // enable is only looked at here and in IDLE, so dropping it
                // mid-frame never truncates a frame.
                if (w_eop_accept) begin
                    if (enable) begin
                        w_state_nxt = S_RUN;
                        w_restart   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scan counters: advance only on an issue; hold on the last pixel
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (w_restart) begin
            r_pix <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (w_issue && !w_last) begin
            r_pix <= r_pix + c_PIX_W'(1);
            if (r_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= r_y + c_Y_W'(1);
            end else begin
                r_x <= r_x + c_X_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
            r_tag_sop  <= 1'b0;
            r_tag_eop  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_tag_sop  <= w_issue && w_first;
            r_tag_eop  <= w_issue && w_last;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. On a simultaneous push/pop at count==1 the read pointer
    // moves onto the slot being written, so the new entry is the next head.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= {r_tag_eop, r_tag_sop, sram_readdata};
                r_wptr         <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame completion pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (r_state == S_DRAIN) && w_eop_accept;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sram_address    = BASE_ADDR + ADDR_W'(r_pix);
    assign sram_chipselect = w_issue;
    assign sram_write      = 1'b0;
    assign sram_writedata  = 8'h00;
    assign sram_clken      = 1'b1;

    assign st_valid   = (r_count != 3'd0);
    assign st_data    = w_head[7:0];
    // Markers gated by valid so a stale head never shows sop/eop.
    assign st_sop     = st_valid && w_head[8];
    assign st_eop     = st_valid && w_head[9];
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sram_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sram_frame_reader
// Description : Scoreboard bench for sram_frame_reader. A 4x2 instance covers
//               streaming, backpressure, back-to-back frames, enable drop and
//               async reset; a 4x1 instance at the top of the address space
//               covers address wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_frame_reader;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        enable;
    logic        st_ready;
    logic [16:0] sram_address;
    logic        sram_chipselect;
    logic        sram_write;
    logic [7:0]  sram_writedata;
    logic        sram_clken;
    logic [7:0]  sram_readdata;
    logic [7:0]  st_data;
    logic        st_valid;
    logic        st_sop;
    logic        st_eop;
    logic        busy;
    logic        frame_done;

    logic        x_enable;
    logic        x_ready;
    logic [16:0] x_address;
    logic        x_cs;
    logic        x_write;
    logic [7:0]  x_writedata;
    logic        x_clken;
    logic [7:0]  x_readdata;
    logic [7:0]  x_data;
    logic        x_valid;
    logic        x_sop;
    logic        x_eop;
    logic        x_busy;
    logic        x_done;

    sram_frame_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(17), .BASE_ADDR(17'h00000)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .sram_address(sram_address), .sram_chipselect(sram_chipselect),
        .sram_write(sram_write), .sram_writedata(sram_writedata),
        .sram_clken(sram_clken), .sram_readdata(sram_readdata),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop), .busy(busy), .frame_done(frame_done)
    );

    sram_frame_reader #(.WIDTH(4), .HEIGHT(1), .ADDR_W(17), .BASE_ADDR(17'h1FFFE)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .enable(x_enable),
        .sram_address(x_address), .sram_chipselect(x_cs),
        .sram_write(x_write), .sram_writedata(x_writedata),
        .sram_clken(x_clken), .sram_readdata(x_readdata),
        .st_data(x_data), .st_valid(x_valid), .st_ready(x_ready),
        .st_sop(x_sop), .st_eop(x_eop), .busy(x_busy), .frame_done(x_done)
    );

    // SRAM models: mem[a] = a[7:0] ^ 0x5A with one cycle of read latency.
    always @(posedge clk) begin
        sram_readdata <= sram_address[7:0] ^ 8'h5A;
        x_readdata    <= x_address[7:0] ^ 8'h5A;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard and observation records
    logic [9:0]  exp_q[$];
    int          beat_t[$];
    logic [1:0]  beat_se[$];
    int          fd_t[$];
    logic        fd_busy[$];
    logic [16:0] x_addr_q[$];

    logic        m_pop;
    logic [9:0]  m_beat;
    logic [9:0]  m_exp;
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic [9:0]  p_beat  = '0;
    int          outst     = 0;
    int          max_outst = 0;
    int          n_cs      = 0;
    int          n_sop     = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            p_valid = 1'b0;
            p_ready = 1'b0;
            outst   = 0;
        end else begin
            m_pop  = st_valid && st_ready;
            m_beat = {st_eop, st_sop, st_data};
            if (p_valid && !p_ready) begin
                chk("stall_valid", 32'(st_valid), 32'd1);
                chk("stall_beat", 32'(m_beat), 32'(p_beat));
            end
            if (sram_chipselect) begin
                n_cs++;
                chk("issue_rule", 32'((outst - int'(m_pop)) < 4), 32'd1);
            end
            outst = outst + int'(sram_chipselect) - int'(m_pop);
            if (outst > max_outst) max_outst = outst;
            if (m_pop) begin
                chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    m_exp = exp_q.pop_front();
                    chk("beat", 32'(m_beat), 32'(m_exp));
                end
                beat_t.push_back(cyc);
                beat_se.push_back({st_sop, st_eop});
                if (st_sop) n_sop++;
            end
            if (frame_done) begin
                fd_t.push_back(cyc);
                fd_busy.push_back(busy);
            end
            p_valid = st_valid;
            p_ready = st_ready;
            p_beat  = m_beat;
        end
        if (x_cs) x_addr_q.push_back(x_address);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({(i == N - 1), (i == 0), (8'(i) ^ 8'h5A)});
        end
    endtask

    task automatic clear_rec();
        beat_t.delete();
        beat_se.delete();
        fd_t.delete();
        fd_busy.delete();
        n_sop = 0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, 32'(exp_q.size() == 0 && !busy), 32'd1);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_en;
        int k;
        int cs_before;
        int ns;
        int ne;
        logic [7:0] sm;
        logic [7:0] em;

        reset_n  = 1'b0;
        enable   = 1'b0;
        st_ready = 1'b1;
        x_enable = 1'b0;
        x_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_valid", 32'(st_valid), 32'd0);
        chk("rst_cs", 32'(sram_chipselect), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_addr", 32'(sram_address), 32'h0);
        chk("rst_sop_eop", 32'({st_sop, st_eop}), 32'd0);
        chk("tie_write", 32'(sram_write), 32'd0);
        chk("tie_wdata", 32'(sram_writedata), 32'd0);
        chk("tie_clken", 32'(sram_clken), 32'd1);

        // Single frame with st_ready held high
        clear_rec();
        tick();
        enable = 1'b1;
        t_en   = cyc;
        push_frame();
        tick();
        enable = 1'b0;
        wait_drain("single", 60);
        chk("single_beats", 32'(beat_t.size()), 32'(N));
        if (beat_t.size() == N) begin
            chk("first_latency", 32'(beat_t[0] - t_en), 32'd3);
            chk("no_bubbles", 32'(beat_t[N-1] - beat_t[0]), 32'(N - 1));
            sm = '0;
            em = '0;
            for (int i = 0; i < N; i++) begin
                sm[i] = beat_se[i][1];
                em[i] = beat_se[i][0];
            end
            chk("sop_mask", 32'(sm), 32'h01);
            chk("eop_mask", 32'(em), 32'h80);
            chk("done_count", 32'(fd_t.size()), 32'd1);
            if (fd_t.size() == 1) begin
                chk("done_time", 32'(fd_t[0] - beat_t[N-1]), 32'd1);
                chk("busy_at_done", 32'(fd_busy[0]), 32'd0);
            end
        end

        // Random backpressure, starting with a full stall to fill the FIFO
        clear_rec();
        max_outst = 0;
        st_ready  = 1'b0;
        tick();
        enable = 1'b1;
        push_frame();
        tick();
        enable = 1'b0;
        repeat (8) tick();
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 400) begin
            st_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("bp_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
        st_ready = 1'b1;
        repeat (2) tick();
        chk("bp_beats", 32'(beat_t.size()), 32'(N));
        chk("bp_occ_max", 32'(max_outst), 32'd4);

        // Continuous frames with enable held high
        clear_rec();
        tick();
        enable = 1'b1;
        repeat (3) push_frame();
        k = 0;
        while (n_sop < 3 && k < 200) begin
            tick();
            k++;
        end
        enable = 1'b0;
        wait_drain("cont", 200);
        chk("cont_beats", 32'(beat_t.size()), 32'(3 * N));
        ns = 0;
        ne = 0;
        for (int i = 0; i < beat_se.size(); i++) begin
            if (beat_se[i][1]) ns++;
            if (beat_se[i][0]) ne++;
            if (beat_se[i][0] && (i + 1 < beat_t.size())) begin
                chk("frame_gap", 32'(beat_t[i+1] - beat_t[i]), 32'd3);
            end
        end
        chk("cont_sops", 32'(ns), 32'd3);
        chk("cont_eops", 32'(ne), 32'd3);
        chk("cont_dones", 32'(fd_t.size()), 32'd3);

        // Enable dropped mid-frame: the frame still completes
        clear_rec();
        tick();
        enable = 1'b1;
        push_frame();
        k = 0;
        while (beat_t.size() < 3 && k < 50) begin
            tick();
            k++;
        end
        enable = 1'b0;
        wait_drain("drop", 60);
        chk("drop_beats", 32'(beat_t.size()), 32'(N));
        cs_before = n_cs;
        repeat (20) tick();
        chk("drop_no_cs", 32'(n_cs - cs_before), 32'd0);
        chk("drop_idle", 32'(busy), 32'd0);

        // Async reset mid-frame while stalled
        clear_rec();
        tick();
        enable = 1'b1;
        push_frame();
        tick();
        enable = 1'b0;
        k = 0;
        while (beat_t.size() < 5 && k < 50) begin
            tick();
            k++;
        end
        st_ready = 1'b0;
        repeat (2) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(st_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cs", 32'(sram_chipselect), 32'd0);
        chk("arst_addr", 32'(sram_address), 32'h0);
        chk("arst_sop_eop", 32'({st_sop, st_eop}), 32'd0);
        exp_q.delete();
        #14 reset_n = 1'b1;
        clear_rec();
        tick();
        st_ready = 1'b1;
        enable   = 1'b1;
        t_en     = cyc;
        push_frame();
        tick();
        enable = 1'b0;
        wait_drain("restart", 60);
        chk("restart_beats", 32'(beat_t.size()), 32'(N));
        if (beat_t.size() > 0) begin
            chk("restart_latency", 32'(beat_t[0] - t_en), 32'd3);
            chk("restart_sop", 32'(beat_se[0][1]), 32'd1);
        end

        // Address wrap on the 4x1 instance at the top of the address space
        x_addr_q.delete();
        tick();
        x_enable = 1'b1;
        tick();
        x_enable = 1'b0;
        k = 0;
        while ((x_busy || x_addr_q.size() < 4) && k < 50) begin
            tick();
            k++;
        end
        chk("wrap_count", 32'(x_addr_q.size()), 32'd4);
        if (x_addr_q.size() == 4) begin
            chk("wrap_a0", 32'(x_addr_q[0]), 32'h1FFFE);
            chk("wrap_a1", 32'(x_addr_q[1]), 32'h1FFFF);
            chk("wrap_a2", 32'(x_addr_q[2]), 32'h00000);
            chk("wrap_a3", 32'(x_addr_q[3]), 32'h00001);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
